// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified-memory port arbiter: FSM states, owner tags
// and access-size codes.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between IF and D plus the tie-break history register.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin ties instead of D priority with IF starvation guard.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic if_req,
  input  logic d_req,
  output logic if_win,
  output logic d_win
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_owner_r;

  // Pick the winner; on a tie the requester not granted last time wins.
  always_comb begin
    if_win = 1'b0;
    d_win  = 1'b0;
    if (en) begin
      if (if_req && d_req) begin
        if (last_owner_r == OWN_IF) begin
          d_win = 1'b1;
        end else begin
          if_win = 1'b1;
        end
      end else begin
        if_win = if_req;
        d_win  = d_req;
      end
    end else begin
      if_win = 1'b0;
      d_win  = 1'b0;
    end
  end

  // Remember which requester took the most recent grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_owner_r <= OWN_IF;
    end else if (d_win) begin
      last_owner_r <= OWN_D;
    end else if (if_win) begin
      last_owner_r <= OWN_IF;
    end else begin
      last_owner_r <= last_owner_r;
    end
  end
`else
  logic [3:0] starve_cnt_r;
  logic       force_if_s;

  assign force_if_s = (starve_cnt_r >= 4'(STARVE_LIMIT));

  // Pick the winner; D has priority until IF has lost STARVE_LIMIT ties in a row.
  always_comb begin
    if_win = 1'b0;
    d_win  = 1'b0;
    if (en) begin
      if (if_req && d_req) begin
        if (force_if_s) begin
          if_win = 1'b1;
        end else begin
          d_win = 1'b1;
        end
      end else begin
        if_win = if_req;
        d_win  = d_req;
      end
    end else begin
      if_win = 1'b0;
      d_win  = 1'b0;
    end
  end

  // Count consecutive lost IF ties, saturating at 15, cleared on an IF grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_r <= 4'd0;
    end else if (if_win) begin
      starve_cnt_r <= 4'd0;
    end else if (d_win && if_req && (starve_cnt_r != 4'd15)) begin
      starve_cnt_r <= starve_cnt_r + 4'd1;
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store, one access at a time.
// Optional macro MEM_ARB_ROUND_ROBIN_EN switches tie-breaking to round-robin (see mem_arb_pick).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [1:0]        d_size,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic [1:0]        m_size,
  input  logic              m_gnt,
  input  logic              m_rvalid,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy
);

  state_e            state_r, state_s;
  logic              owner_r;
  logic [ADDR_W-1:0] addr_r;
  logic              we_r;
  logic [DATA_W-1:0] wdata_r;
  logic [1:0]        size_r;
  logic [DATA_W-1:0] if_rdata_r, d_rdata_r;
  logic              if_rvalid_r, d_rvalid_r;
  logic              arb_en_s, if_win_s, d_win_s;

  // Grants are only offered in IDLE and never while reset is asserted.
  assign arb_en_s = (state_r == IDLE) && !rst;

  mem_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
    .clk    (clk),
    .rst    (rst),
    .en     (arb_en_s),
    .if_req (if_req),
    .d_req  (d_req),
    .if_win (if_win_s),
    .d_win  (d_win_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (if_win_s || d_win_s) state_s = ISSUE;
        else                     state_s = IDLE;
      end
      ISSUE: begin
        if (m_gnt) state_s = we_r ? IDLE : WAIT;
        else       state_s = ISSUE;
      end
      WAIT: begin
        if (m_rvalid) state_s = IDLE;
        else          state_s = WAIT;
      end
      default: state_s = IDLE;
    endcase
  end

  // Latch the winning request and capture read responses for their owner.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_r     <= OWN_IF;
      addr_r      <= {ADDR_W{1'b0}};
      we_r        <= 1'b0;
      wdata_r     <= {DATA_W{1'b0}};
      size_r      <= 2'b00;
      if_rdata_r  <= {DATA_W{1'b0}};
      d_rdata_r   <= {DATA_W{1'b0}};
      if_rvalid_r <= 1'b0;
      d_rvalid_r  <= 1'b0;
    end else begin
      if_rvalid_r <= 1'b0;
      d_rvalid_r  <= 1'b0;
      if (d_win_s) begin
        owner_r <= OWN_D;
        addr_r  <= d_addr;
        we_r    <= d_we;
        wdata_r <= d_wdata;
        size_r  <= d_size;
      end else if (if_win_s) begin
        owner_r <= OWN_IF;
        addr_r  <= if_addr;
        we_r    <= 1'b0;
        wdata_r <= {DATA_W{1'b0}};
        size_r  <= SZ_WORD;
      end
      if ((state_r == WAIT) && m_rvalid) begin
        if (owner_r == OWN_D) begin
          d_rdata_r  <= m_rdata;
          d_rvalid_r <= 1'b1;
        end else begin
          if_rdata_r  <= m_rdata;
          if_rvalid_r <= 1'b1;
        end
      end
    end
  end

  // FSM outputs; write enable is qualified so a stale store never leaks outside ISSUE.
  always_comb begin
    m_req     = (state_r == ISSUE);
    m_we      = (state_r == ISSUE) && we_r;
    m_addr    = addr_r;
    m_wdata   = wdata_r;
    m_size    = size_r;
    busy      = (state_r != IDLE);
    if_gnt    = if_win_s;
    d_gnt     = d_win_s;
    if_rvalid = if_rvalid_r;
    if_rdata  = if_rdata_r;
    d_rvalid  = d_rvalid_r;
    d_rdata   = d_rdata_r;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; inputs change 2 time units after
// the rising edge and outputs are checked 1 unit later.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we, m_gnt, m_rvalid;
  logic [31:0] if_addr, d_addr, d_wdata, m_rdata;
  logic [1:0]  d_size;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, m_req, m_we, busy;
  logic [31:0] if_rdata, d_rdata, m_addr, m_wdata;
  logic [1:0]  m_size;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_size(m_size),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .busy(busy)
  );

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset;
    rst = 1'b1; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; m_gnt = 1'b0; m_rvalid = 1'b0;
    if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; d_size = 2'b00; m_rdata = 32'h0;
    step; step;
    #1;
    n_cmp++;
    if ({if_gnt, d_gnt, if_rvalid, d_rvalid, m_req, m_we, busy} !== 7'b0) begin
      n_bad++; $display("FAIL reset_ctrl: got %b expected 0000000", {if_gnt, d_gnt, if_rvalid, d_rvalid, m_req, m_we, busy});
    end
    n_cmp++;
    if ({if_rdata, d_rdata, m_addr, m_wdata, m_size} !== 130'b0) begin
      n_bad++; $display("FAIL reset_data: got %h %h %h %h %b expected all 0", if_rdata, d_rdata, m_addr, m_wdata, m_size);
    end
    if_req = 1'b0; d_req = 1'b0; rst = 1'b0;
  endtask

  task automatic test_reset_mid_read;
    step;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; d_size = 2'b10;
    #1;
    n_cmp++;
    if (d_gnt !== 1'b1) begin n_bad++; $display("FAIL rmr_gnt: got %b expected 1", d_gnt); end
    step;
    d_req = 1'b0; m_gnt = 1'b1;
    step;
    m_gnt = 1'b0;
    #1;
    n_cmp++;
    if ({busy, m_req} !== 2'b10) begin n_bad++; $display("FAIL rmr_wait: got %b expected 10", {busy, m_req}); end
    rst = 1'b1;
    step;
    rst = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hDEADBEEF;
    #1;
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL rmr_idle: got busy %b expected 0", busy); end
    step;
    m_rvalid = 1'b0;
    #1;
    n_cmp++;
    if ({d_rvalid, if_rvalid, busy} !== 3'b000 || d_rdata !== 32'h0) begin
      n_bad++; $display("FAIL rmr_drop: got rv %b%b busy %b rdata %h expected 000 00000000", d_rvalid, if_rvalid, busy, d_rdata);
    end
  endtask

  task automatic test_if_read;
    step;
    if_req = 1'b1; if_addr = 32'h100;
    #1;
    n_cmp++;
    if ({if_gnt, d_gnt, m_req} !== 3'b100) begin n_bad++; $display("FAIL ifr_gnt: got %b expected 100", {if_gnt, d_gnt, m_req}); end
    step;
    if_req = 1'b0; m_gnt = 1'b1;
    #1;
    n_cmp++;
    if ({m_req, m_we, m_size} !== 4'b1010 || m_addr !== 32'h100 || if_gnt !== 1'b0) begin
      n_bad++; $display("FAIL ifr_issue: got req/we/size %b addr %h gnt %b expected 1010 00000100 0", {m_req, m_we, m_size}, m_addr, if_gnt);
    end
    step;
    m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h00500093;
    #1;
    n_cmp++;
    if ({m_req, busy, if_rvalid} !== 3'b010) begin n_bad++; $display("FAIL ifr_wait: got %b expected 010", {m_req, busy, if_rvalid}); end
    step;
    m_rvalid = 1'b0; m_rdata = 32'h0;
    #1;
    n_cmp++;
    if ({if_rvalid, d_rvalid, busy} !== 3'b100 || if_rdata !== 32'h00500093) begin
      n_bad++; $display("FAIL ifr_rvalid: got rv %b%b busy %b rdata %h expected 100 00500093", if_rvalid, d_rvalid, busy, if_rdata);
    end
    step;
    #1;
    n_cmp++;
    if (if_rvalid !== 1'b0 || if_rdata !== 32'h00500093) begin
      n_bad++; $display("FAIL ifr_hold: got rv %b rdata %h expected 0 00500093", if_rvalid, if_rdata);
    end
  endtask

  task automatic test_store;
    step;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'h12345678; d_size = 2'b01;
    #1;
    n_cmp++;
    if (d_gnt !== 1'b1) begin n_bad++; $display("FAIL st_gnt: got %b expected 1", d_gnt); end
    for (int k = 0; k < 4; k++) begin
      step;
      d_req = 1'b0; d_wdata = 32'hFFFFFFFF; d_addr = 32'hFFFFFFFF;
      m_gnt = (k == 3);
      #1;
      n_cmp++;
      if ({m_req, m_we, m_size} !== 4'b1101 || m_addr !== 32'h80 || m_wdata !== 32'h12345678) begin
        n_bad++; $display("FAIL st_issue%0d: got %b %h %h expected 1101 00000080 12345678", k, {m_req, m_we, m_size}, m_addr, m_wdata);
      end
    end
    step;
    m_gnt = 1'b0; d_we = 1'b0;
    #1;
    n_cmp++;
    if ({busy, m_req, d_rvalid, if_rvalid} !== 4'b0000) begin
      n_bad++; $display("FAIL st_done: got %b expected 0000", {busy, m_req, d_rvalid, if_rvalid});
    end
    step;
    #1;
    n_cmp++;
    if ({d_rvalid, if_rvalid} !== 2'b00) begin n_bad++; $display("FAIL st_norv: got %b expected 00", {d_rvalid, if_rvalid}); end
  endtask

  task automatic test_contention;
    logic exp_d, prev_d;
    prev_d = 1'b0;
    rst = 1'b1;
    step;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step;
      if_req = 1'b1; if_addr = 32'h200; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; d_size = 2'b10;
      m_gnt = 1'b1; m_rvalid = 1'b1; m_rdata = 32'hC0000000 + 32'(i);
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_d = ((i % 2) == 0);
`else
      exp_d = ((i % 5) != 4);
`endif
      #1;
      n_cmp++;
      if ({d_gnt, if_gnt} !== {exp_d, ~exp_d}) begin
        n_bad++; $display("FAIL cont_gnt%0d: got d/if %b%b expected %b%b", i, d_gnt, if_gnt, exp_d, ~exp_d);
      end
      if (i > 0) begin
        n_cmp++;
        if ({d_rvalid, if_rvalid} !== {prev_d, ~prev_d} ||
            (prev_d ? d_rdata : if_rdata) !== 32'hC0000000 + 32'(i - 1)) begin
          n_bad++; $display("FAIL cont_rv%0d: got d/if %b%b data %h/%h expected %b%b %h", i, d_rvalid, if_rvalid,
                            d_rdata, if_rdata, prev_d, ~prev_d, 32'hC0000000 + 32'(i - 1));
        end
      end
      prev_d = exp_d;
      step;
      step;
    end
    if_req = 1'b0; d_req = 1'b0; m_gnt = 1'b0; m_rvalid = 1'b0;
  endtask

  task automatic test_spurious;
    rst = 1'b1;
    step;
    rst = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h11111111;
    step;
    m_rvalid = 1'b0;
    #1;
    n_cmp++;
    if ({busy, if_rvalid, d_rvalid} !== 3'b000) begin n_bad++; $display("FAIL sp_idle: got %b expected 000", {busy, if_rvalid, d_rvalid}); end
    if_req = 1'b1; if_addr = 32'h104;
    step;
    if_req = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h22222222;
    step;
    m_rvalid = 1'b0;
    #1;
    n_cmp++;
    if ({m_req, busy, if_rvalid, d_rvalid} !== 4'b1100) begin
      n_bad++; $display("FAIL sp_issue: got %b expected 1100", {m_req, busy, if_rvalid, d_rvalid});
    end
    m_gnt = 1'b1;
    step;
    m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hA5A5A5A5;
    step;
    m_rvalid = 1'b0;
    #1;
    n_cmp++;
    if ({if_rvalid, d_rvalid} !== 2'b10 || if_rdata !== 32'hA5A5A5A5) begin
      n_bad++; $display("FAIL sp_resp: got rv %b%b data %h expected 10 a5a5a5a5", if_rvalid, d_rvalid, if_rdata);
    end
  endtask

  initial begin
    test_reset;
    test_reset_mid_read;
    test_if_read;
    test_store;
    test_contention;
    test_spurious;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between instruction fetch (IF) and load/store (D) requesters.
- Lets the core run from one memory macro instead of separate imem/data_memory instances.
- Sequences each access with an FSM: accept, issue to memory, await read response, return data to the owner.
- Priority is fixed to D, with a starvation guard for IF; one transaction is outstanding at a time.

Parameters:
- ADDR_W, 32, address width for all ports.
- DATA_W, 32, data width for all ports.
- STARVE_LIMIT, 4, consecutive lost IF arbitrations before IF is forced to win; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- if_req  in  1  IF request; held with if_addr until if_gnt.
- if_addr  in  ADDR_W  fetch byte address.
- if_gnt  out  1  one-cycle pulse: IF request accepted.
- if_rvalid  out  1  one-cycle pulse: if_rdata valid.
- if_rdata  out  DATA_W  fetched word.
- d_req  in  1  data request; fields held until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  DATA_W  store data.
- d_size  in  2  00 byte, 01 half, 10 word; passed through unchanged.
- d_gnt  out  1  one-cycle pulse: D request accepted.
- d_rvalid  out  1  one-cycle pulse: d_rdata valid (loads only).
- d_rdata  out  DATA_W  load data.
- m_req  out  1  memory request, held until m_gnt.
- m_we  out  1  memory write enable.
- m_addr  out  ADDR_W  memory address.
- m_wdata  out  DATA_W  memory write data.
- m_size  out  2  memory access size.
- m_gnt  in  1  memory accepts request this cycle.
- m_rvalid  in  1  read data valid.
- m_rdata  in  DATA_W  read data.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE; starve_cnt = 0.
  - All outputs 0, including all rdata buses and m_* fields.
  - Any outstanding transaction is dropped.
  - A m_rvalid arriving after reset is ignored.
- IDLE:
  - Arbitration when neither request is present: no action.
  - Only one request present: that request wins.
  - Both present: D wins unless starve_cnt >= STARVE_LIMIT, in which case IF wins.
  - On a win: latch addr, we, wdata and size (IF: we = 0, size = 10, wdata = 0) plus the owner; pulse the winner's gnt in the same cycle; go to ISSUE.
- starve_cnt:
  - Increments (saturating at 15) when IF loses a both-present arbitration.
  - Clears when IF is granted.
  - Unchanged otherwise.
- ISSUE:
  - m_req = 1 and m_* are driven from the latched registers.
  - If m_gnt and the access is a write: go to IDLE; no rvalid is produced.
  - If m_gnt and the access is a read: go to WAIT.
  - m_rvalid is ignored in ISSUE.
- WAIT:
  - m_req = 0.
  - On m_rvalid: register m_rdata into the owner's rdata, pulse the owner's rvalid next cycle, and go to IDLE.
  - The other requester's rdata/rvalid stay unchanged / 0.
- Latency and throughput:
  - Read with m_gnt and m_rvalid each arriving one cycle after the prior state: gnt at T, m_req at T+1, rvalid at T+3.
  - Minimum: 3 cycles per read, 2 cycles per write.
- Requests are not accepted in ISSUE or WAIT. Requesters hold their fields; a request dropped before gnt is simply not served.
- rdata registers retain their last value until the next response for that requester.
- The gnt pulses and rvalid pulses of the two requesters are never high in the same cycle.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined:
  - starve_cnt and STARVE_LIMIT logic are removed.
  - A 1-bit last_owner register (reset 0 = IF) decides ties: the requester that was not last granted wins.
  - last_owner updates on every gnt.
- Undefined: fixed D priority with the starvation guard, as described in Behaviour.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encoding IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2;
  - owner encoding OWN_IF = 1'b0, OWN_D = 1'b1;
  - size constants SZ_BYTE, SZ_HALF, SZ_WORD.
- One sub-module, mem_arb_pick: combinational winner selection plus the starve_cnt / last_owner register. It isolates the priority policy so the optional feature changes only this module.

Test Plan:
- Reset mid-read:
  - Stimulus: D load to 0x40 in WAIT; assert rst for 1 cycle; then m_rvalid with 0xDEADBEEF.
  - Required: state = IDLE; d_rvalid stays 0; d_rdata stays 0.
- Single IF read:
  - Stimulus: if_req with addr 0x100; m_gnt one cycle after m_req; m_rvalid with 0x00500093 one cycle after that.
  - Required: if_gnt at T, m_addr = 0x100, m_we = 0, m_size = 10; if_rvalid at T+3 with if_rdata = 0x00500093.
- Store:
  - Stimulus: d_req, d_we = 1, addr 0x80, wdata 0x12345678, size 01; m_gnt after 3 wait cycles.
  - Required: m_req held 4 cycles with stable fields; return to IDLE; no rvalid pulse.
- Contention, default build:
  - Stimulus: if_req and d_req held continuously, STARVE_LIMIT = 4.
  - Required: grant sequence D, D, D, D, IF, repeating.
- Contention, MEM_ARB_ROUND_ROBIN_EN defined:
  - Stimulus: same as above.
  - Required: grant sequence D, IF, D, IF.
- Spurious response:
  - Stimulus: m_rvalid pulsed while in IDLE and while in ISSUE.
  - Required: no rvalid on either requester; state is unaffected.
